// File: rtl/trace_hex_serializer.sv
// Formats a p_nbits message as lowercase ASCII hex, MSB nibble first, one
// character per cycle, optionally followed by a separator byte.
module trace_hex_serializer #(
  parameter int          p_nbits  = 32,
  parameter logic [7:0]  p_sep    = 8'h20,
  localparam int         p_nchars = (p_nbits + 3) / 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_msg,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [7:0]         out_char,
  output logic               out_last,
  output logic [15:0]        msg_count
);

  // Handshake: a transfer happens on a rising clk edge where val && rdy.
  // A producer holds val (and its payload) stable until the transfer.

  localparam int            W        = 4 * p_nchars;
  localparam int            IW       = (p_nchars > 1) ? $clog2(p_nchars) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(p_nchars - 1);
  localparam bit            HAS_SEP  = (p_sep != 8'h00);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_SEP
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    msg_q, msg_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [W-1:0]    msg_ext;
  logic [W-1:0]    msg_shifted;
  logic [3:0]      nib;
  logic            out_fire;
  logic            finish;
  logic            in_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      msg_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    msg_ext              = '0;
    msg_ext[p_nbits-1:0] = in_msg;
    msg_shifted          = msg_q >> {idx_q, 2'b00};
    nib                  = msg_shifted[3:0];

    out_val  = (state_q != ST_IDLE);
    out_last = (state_q == ST_SEP) ||
               ((state_q == ST_EMIT) && (idx_q == '0) && !HAS_SEP);
    case (state_q)
      ST_EMIT: out_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib})
                                        : (8'h57 + {4'h0, nib});
      ST_SEP:  out_char = p_sep;
      default: out_char = 8'h00;
    endcase

    out_fire = out_val && out_rdy;
    finish   = out_fire && out_last;
    // Accepting during the final character's transfer removes the bubble.
    in_rdy   = !reset && ((state_q == ST_IDLE) || finish);
    in_fire  = in_val && in_rdy;

    state_d = state_q;
    msg_d   = msg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          msg_d   = msg_ext;
          idx_d   = LAST_IDX;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_fire) begin
          if (idx_q != '0) begin
            idx_d = idx_q - IW'(1);
          end else if (HAS_SEP) begin
            state_d = ST_SEP;
          end
        end
      end
      default: ;
    endcase

    if (finish) begin
      cnt_d = cnt_q + 16'd1;
      if (in_fire) begin
        msg_d   = msg_ext;
        idx_d   = LAST_IDX;
        state_d = ST_EMIT;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  assign msg_count = cnt_q;

endmodule

// File: tb/tb_trace_hex_serializer.sv
// Randomized and directed bench for trace_hex_serializer; three instances
// cover the default format, a narrow no-separator format and counter wrap.
module tb_trace_hex_serializer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: 32-bit messages, space separator
  logic        a_in_val, a_in_rdy, a_out_val, a_out_rdy, a_out_last;
  logic [31:0] a_in_msg;
  logic [7:0]  a_out_char;
  logic [15:0] a_msg_count;

  // Instance B: 10-bit messages, no separator
  logic        b_in_val, b_in_rdy, b_out_val, b_out_rdy, b_out_last;
  logic [9:0]  b_in_msg;
  logic [7:0]  b_out_char;
  logic [15:0] b_msg_count;

  // Instance C: single-nibble messages, no separator, used for counter wrap
  logic        c_in_val, c_in_rdy, c_out_val, c_out_rdy, c_out_last;
  logic [3:0]  c_in_msg;
  logic [7:0]  c_out_char;
  logic [15:0] c_msg_count;

  trace_hex_serializer #(.p_nbits(32), .p_sep(8'h20)) dut_a (
    .clk(clk), .reset(reset), .in_val(a_in_val), .in_rdy(a_in_rdy),
    .in_msg(a_in_msg), .out_val(a_out_val), .out_rdy(a_out_rdy),
    .out_char(a_out_char), .out_last(a_out_last), .msg_count(a_msg_count));

  trace_hex_serializer #(.p_nbits(10), .p_sep(8'h00)) dut_b (
    .clk(clk), .reset(reset), .in_val(b_in_val), .in_rdy(b_in_rdy),
    .in_msg(b_in_msg), .out_val(b_out_val), .out_rdy(b_out_rdy),
    .out_char(b_out_char), .out_last(b_out_last), .msg_count(b_msg_count));

  trace_hex_serializer #(.p_nbits(4), .p_sep(8'h00)) dut_c (
    .clk(clk), .reset(reset), .in_val(c_in_val), .in_rdy(c_in_rdy),
    .in_msg(c_in_msg), .out_val(c_out_val), .out_rdy(c_out_rdy),
    .out_char(c_out_char), .out_last(c_out_last), .msg_count(c_msg_count));

  // Scoreboard entries are {last, char}
  logic [8:0]  exp_q[$];
  logic [31:0] msg_q[$];

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Reference formatter: hex digits MSB first, then optional separator
  function automatic void push_msg(input logic [63:0] m, input int nchars,
                                   input logic [7:0] sep);
    logic [63:0] sh;
    for (int i = nchars - 1; i >= 0; i--) begin
      sh = m >> (4 * i);
      exp_q.push_back({(i == 0) && (sep == 8'h00), hex_ch(sh[3:0])});
    end
    if (sep != 8'h00) exp_q.push_back({1'b1, sep});
  endfunction

  // Streams msg_q through instance A; span = cycles from first valid char
  // to the last transfer inclusive.
  task automatic stream_a(input int in_pct, input int rdy_pct,
                          input int stall_at, input int stall_len,
                          output int span);
    int          n = msg_q.size();
    int          cyc = 0, fired = 0, first = -1, last_fire = -1;
    int          stall_left = stall_len;
    logic [15:0] cnt0 = a_msg_count;
    logic [7:0]  prev_char = 8'h00;
    bit          prev_stall = 1'b0;
    logic        exp_rdy;
    logic [8:0]  head;
    exp_q.delete();
    while ((msg_q.size() > 0 || exp_q.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      a_in_val = (msg_q.size() > 0) && ($urandom_range(99) < in_pct);
      a_in_msg = a_in_val ? msg_q[0] : $urandom;
      if (exp_q.size() > 0 && fired == stall_at && stall_left > 0) begin
        a_out_rdy = 1'b0;
        stall_left--;
      end else begin
        a_out_rdy = ($urandom_range(99) < rdy_pct);
      end
      #1;
      exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && a_out_rdy);
      n_checks++;
      if (a_out_val !== (exp_q.size() != 0)) begin
        n_errors++;
        $display("FAIL a_out_val cyc=%0d got=%b exp=%b", cyc, a_out_val, exp_q.size() != 0);
      end
      n_checks++;
      if (a_in_rdy !== exp_rdy) begin
        n_errors++;
        $display("FAIL a_in_rdy cyc=%0d got=%b exp=%b", cyc, a_in_rdy, exp_rdy);
      end
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        n_checks++;
        if ({a_out_last, a_out_char} !== head) begin
          n_errors++;
          $display("FAIL a_char cyc=%0d got=%b/%h exp=%b/%h", cyc, a_out_last, a_out_char,
                   head[8], head[7:0]);
        end
        if (prev_stall) begin
          n_checks++;
          if (a_out_char !== prev_char) begin
            n_errors++;
            $display("FAIL a_hold cyc=%0d got=%h exp=%h", cyc, a_out_char, prev_char);
          end
        end
        if (first < 0) first = cyc;
        if (a_out_rdy) begin
          void'(exp_q.pop_front());
          fired++;
          last_fire = cyc;
        end
      end
      if (a_in_val && exp_rdy) push_msg(64'(msg_q.pop_front()), 8, 8'h20);
      prev_stall = a_out_val && !a_out_rdy;
      prev_char  = a_out_char;
      cyc++;
    end
    n_checks++;
    if (cyc >= 5000) begin
      n_errors++;
      $display("FAIL a_stream_timeout got=%0d cycles exp=<5000", cyc);
    end
    @(negedge clk);
    a_in_val  = 1'b0;
    a_out_rdy = 1'b0;
    #1;
    n_checks++;
    if (a_msg_count !== 16'(cnt0 + n)) begin
      n_errors++;
      $display("FAIL a_msg_count got=%0d exp=%0d", a_msg_count, 16'(cnt0 + n));
    end
    n_checks++;
    if (a_out_val !== 1'b0) begin
      n_errors++;
      $display("FAIL a_idle_after got=%b exp=0", a_out_val);
    end
    span = last_fire - first + 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({a_in_rdy, a_out_val, a_out_last} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags got=%b exp=000", {a_in_rdy, a_out_val, a_out_last});
    end
    n_checks++;
    if (a_out_char !== 8'h00 || a_msg_count !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_values got=%h/%h exp=00/0000", a_out_char, a_msg_count);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({a_in_rdy, b_in_rdy, c_in_rdy} !== 3'b111) begin
      n_errors++;
      $display("FAIL reset_release_rdy got=%b exp=111", {a_in_rdy, b_in_rdy, c_in_rdy});
    end
  endtask

  task automatic test_deadbeef();
    int span;
    msg_q = {32'hdeadbeef};
    stream_a(100, 100, -1, 0, span);
    n_checks++;
    if (span !== 9) begin
      n_errors++;
      $display("FAIL deadbeef_span got=%0d exp=9", span);
    end
  endtask

  task automatic test_stall();
    int span;
    msg_q = {32'hdeadbeef};
    stream_a(100, 100, 2, 3, span);
    n_checks++;
    if (span !== 12) begin
      n_errors++;
      $display("FAIL stall_span got=%0d exp=12", span);
    end
  endtask

  task automatic test_back_to_back();
    int span;
    msg_q = {32'h00000001, 32'h0000000a};
    stream_a(100, 100, -1, 0, span);
    n_checks++;
    if (span !== 18) begin
      n_errors++;
      $display("FAIL b2b_span got=%0d exp=18", span);
    end
  endtask

  task automatic test_random();
    int span;
    msg_q.delete();
    for (int i = 0; i < 40; i++) msg_q.push_back($urandom);
    stream_a(50, 60, -1, 0, span);
    msg_q.delete();
    for (int i = 0; i < 20; i++) msg_q.push_back($urandom);
    stream_a(100, 100, -1, 0, span);
    n_checks++;
    if (span !== 180) begin
      n_errors++;
      $display("FAIL sustained_span got=%0d exp=180", span);
    end
  endtask

  task automatic test_reset_mid();
    int span;
    @(negedge clk);
    a_in_val  = 1'b1;
    a_in_msg  = 32'h12345678;
    a_out_rdy = 1'b1;
    @(negedge clk);
    a_in_val = 1'b0;
    a_in_msg = $urandom;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (a_out_char !== 8'h34 || a_out_val !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_fourth_digit got=%b/%h exp=1/34", a_out_val, a_out_char);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({a_out_val, a_in_rdy, a_out_last} !== 3'b000 || a_out_char !== 8'h00) begin
      n_errors++;
      $display("FAIL mid_reset_async got=%b/%h exp=000/00",
               {a_out_val, a_in_rdy, a_out_last}, a_out_char);
    end
    n_checks++;
    if (a_msg_count !== 16'h0) begin
      n_errors++;
      $display("FAIL mid_reset_count got=%0d exp=0", a_msg_count);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({a_in_rdy, a_out_val} !== 2'b10 || a_msg_count !== 16'h0) begin
      n_errors++;
      $display("FAIL mid_release got=%b/%0d exp=10/0", {a_in_rdy, a_out_val}, a_msg_count);
    end
    msg_q = {32'h00000000};
    stream_a(100, 100, -1, 0, span);
    n_checks++;
    if (span !== 9) begin
      n_errors++;
      $display("FAIL mid_restart_span got=%0d exp=9", span);
    end
  endtask

  task automatic test_narrow();
    logic [9:0]  vals[3];
    logic [15:0] cnt0;
    logic [8:0]  head;
    vals[0] = 10'h3ff;
    vals[1] = 10'($urandom);
    vals[2] = 10'($urandom);
    for (int v = 0; v < 3; v++) begin
      cnt0 = b_msg_count;
      @(negedge clk);
      b_in_val  = 1'b1;
      b_in_msg  = vals[v];
      b_out_rdy = 1'b1;
      #1;
      n_checks++;
      if (b_in_rdy !== 1'b1 || b_out_val !== 1'b0) begin
        n_errors++;
        $display("FAIL narrow_idle got=%b%b exp=10", b_in_rdy, b_out_val);
      end
      exp_q.delete();
      push_msg(64'(vals[v]), 3, 8'h00);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        b_in_val = 1'b0;
        b_in_msg = 10'($urandom);
        #1;
        head = exp_q.pop_front();
        n_checks++;
        if (b_out_val !== 1'b1 || {b_out_last, b_out_char} !== head) begin
          n_errors++;
          $display("FAIL narrow_char v=%0d k=%0d got=%b/%b/%h exp=1/%b/%h", v, k,
                   b_out_val, b_out_last, b_out_char, head[8], head[7:0]);
        end
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (b_out_val !== 1'b0 || b_msg_count !== 16'(cnt0 + 1)) begin
        n_errors++;
        $display("FAIL narrow_done got=%b/%0d exp=0/%0d", b_out_val, b_msg_count,
                 16'(cnt0 + 1));
      end
    end
  endtask

  task automatic test_wrap();
    int         fires = 0, cyc = 0;
    logic [3:0] held = 4'h0;
    bit         checked_top = 1'b0;
    c_out_rdy = 1'b1;
    while (fires < 65536 && cyc < 70000) begin
      @(negedge clk);
      c_in_val = (fires < 65535);
      c_in_msg = 4'($urandom);
      #1;
      if (fires == 65535 && !checked_top) begin
        checked_top = 1'b1;
        n_checks++;
        if (c_msg_count !== 16'hffff) begin
          n_errors++;
          $display("FAIL wrap_top got=%0d exp=65535", c_msg_count);
        end
      end
      if (c_out_val) begin
        n_checks++;
        if (c_out_char !== hex_ch(held) || c_out_last !== 1'b1) begin
          n_errors++;
          $display("FAIL wrap_char cyc=%0d got=%b/%h exp=1/%h", cyc, c_out_last, c_out_char,
                   hex_ch(held));
        end
        if (c_out_rdy) fires++;
      end
      if (c_in_val && c_in_rdy) held = c_in_msg;
      cyc++;
    end
    n_checks++;
    if (cyc >= 70000) begin
      n_errors++;
      $display("FAIL wrap_timeout got=%0d fires exp=65536", fires);
    end
    @(negedge clk);
    c_in_val = 1'b0;
    #1;
    n_checks++;
    if (c_msg_count !== 16'h0 || c_out_val !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_zero got=%0d/%b exp=0/0", c_msg_count, c_out_val);
    end
  endtask

  initial begin
    reset     = 1'b1;
    a_in_val  = 1'b0; a_in_msg = '0; a_out_rdy = 1'b0;
    b_in_val  = 1'b0; b_in_msg = '0; b_out_rdy = 1'b0;
    c_in_val  = 1'b0; c_in_msg = '0; c_out_rdy = 1'b0;
    test_reset();
    test_deadbeef();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_narrow();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
